// File: rtl/fp_unit_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined FP unit among
// NUM_REQ requesters and routes each result back tagged with its requester ID.
module fp_unit_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 14,
  parameter int unsigned ID_W    = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [32*NUM_REQ-1:0]         req_a,
  input  logic [32*NUM_REQ-1:0]         req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fp_go,
  output logic [31:0]                   fp_a,
  output logic [31:0]                   fp_b,
  input  logic                          fp_done,
  input  logic [31:0]                   fp_result,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [31:0]                   resp_data,
  output logic [$clog2(LATENCY+3)-1:0]  inflight,
  output logic                          idle
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 3);

  logic [ID_W-1:0]  ptr_q;
  logic             go_q;
  logic [31:0]      a_q, b_q;
  logic [ID_W-1:0]  issue_id_q;
  logic [LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]  tag_id_q [LATENCY];
  logic             resp_v_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [31:0]      resp_data_q;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic [CNT_W-1:0] rec_q;

  logic             fire;
  logic [ID_W-1:0]  gnt_id;
  logic [31:0]      gnt_a, gnt_b;

  // Scan from ptr+1 upward; the inner loop keeps every index a constant.
  always_comb begin
    req_ready = '0;
    fire      = 1'b0;
    gnt_id    = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!fire && req_valid[i] && (i == (32'(ptr_q) + off) % NUM_REQ)) begin
          fire         = 1'b1;
          req_ready[i] = 1'b1;
          gnt_id       = ID_W'(i);
          gnt_a        = req_a[32*i +: 32];
          gnt_b        = req_b[32*i +: 32];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= ID_W'(NUM_REQ - 1);
      go_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      issue_id_q <= '0;
    end else begin
      go_q <= fire;
      if (fire) begin
        ptr_q      <= gnt_id;
        a_q        <= gnt_a;
        b_q        <= gnt_b;
        issue_id_q <= gnt_id;
      end
    end
  end

  // Tag line: entry LATENCY-1 is loaded alongside fp_go, entry 0 lines up with fp_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i+1];
        tag_id_q[i] <= tag_id_q[i+1];
      end
      tag_v_q[LATENCY-1]  <= go_q;
      tag_id_q[LATENCY-1] <= issue_id_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_v_q    <= 1'b0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
    end else begin
      resp_v_q    <= tag_v_q[0];
      resp_id_q   <= tag_id_q[0];
      resp_data_q <= fp_result;
    end
  end

  always_comb begin
    infl_d = infl_q;
    case ({fire, resp_v_q})
      2'b10:   infl_d = infl_q + CNT_W'(1);
      2'b01:   infl_d = infl_q - CNT_W'(1);
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      infl_q <= '0;
      rec_q  <= CNT_W'(LATENCY);
    end else begin
      infl_q <= infl_d;
      if (rec_q != '0) rec_q <= rec_q - CNT_W'(1);
    end
  end

  // The unit is not reset with us, so its done pulses are untrusted until
  // everything issued before reset has drained out of it.
  a_done_matches_tag: assert property (@(posedge clock) disable iff (reset)
    (rec_q == '0) |-> (fp_done == tag_v_q[0]));

  assign fp_go      = go_q;
  assign fp_a       = a_q;
  assign fp_b       = b_q;
  assign resp_valid = resp_v_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign inflight   = infl_q;
  assign idle       = (infl_q == '0) && !go_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter with a non-resettable 14-cycle subtracting FP unit
// model; a scoreboard tracks every fired operation through to its response.
module tb_fp_unit_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 14;
  localparam int unsigned IDW = 2;
  localparam int unsigned CW  = $clog2(LAT + 3);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NR-1:0]      req_valid = '0;
  logic [32*NR-1:0]   req_a, req_b;
  logic [NR-1:0]      req_ready;
  logic               fp_go;
  logic [31:0]        fp_a, fp_b;
  logic               fp_done;
  logic [31:0]        fp_result;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;
  logic [CW-1:0]      inflight;
  logic               idle;

  logic [31:0] a_cur [NR];
  logic [31:0] b_cur [NR];
  int unsigned op_cnt [NR];
  logic [31:0] a_tab [8] = '{32'h40400000, 32'h40A00000, 32'h41200000, 32'h40F00000,
                             32'h40800000, 32'h40C00000, 32'h3FC00000, 32'h40000000};
  logic [31:0] b_tab [8] = '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3FC00000,
                             32'h40400000, 32'h3F800000, 32'h40800000, 32'h3F000000};

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_a[32*i +: 32] = a_cur[i];
      req_b[32*i +: 32] = b_cur[i];
    end
  end

  fp_unit_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .ID_W(IDW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .fp_go(fp_go), .fp_a(fp_a), .fp_b(fp_b),
    .fp_done(fp_done), .fp_result(fp_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .inflight(inflight), .idle(idle)
  );

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    e = int'(f[30:23]);
    r = (1.0 + real'(int'(f[22:0])) / 8388608.0) * (2.0 ** (e - 127));
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction

  // FP unit model: go to done in LAT cycles, never reset.
  logic [LAT-1:0] u_v = '0;
  logic [31:0]    u_d [LAT] = '{default: '0};
  always @(posedge clock) begin
    u_v    <= {u_v[LAT-2:0], fp_go};
    u_d[0] <= fsub(fp_a, fp_b);
    for (int i = 1; i < LAT; i++) u_d[i] <= u_d[i-1];
  end
  assign fp_done   = u_v[LAT-1];
  assign fp_result = u_d[LAT-1];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    int unsigned    cyc;
  } sb_t;
  sb_t sb[$];

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [NR-1:0] fired_q  = '0;
  logic [NR-1:0] mon_fire;
  logic          exp_go   = 1'b0;
  logic [31:0]   exp_a    = '0;
  logic [31:0]   exp_b    = '0;
  int            exp_infl = 0;
  logic          due;
  sb_t           head;

  always @(negedge clock) begin
    if (reset) begin
      exp_go = 1'b0; exp_a = '0; exp_b = '0; exp_infl = 0;
      sb.delete();
      fired_q = '0;
    end else begin
      chk("fp_go", 64'(fp_go), 64'(exp_go));
      chk("fp_a", 64'(fp_a), 64'(exp_a));
      chk("fp_b", 64'(fp_b), 64'(exp_b));
      chk("inflight", 64'(inflight), 64'(exp_infl));
      chk("idle", 64'(idle), 64'(exp_infl == 0 && !exp_go));
      due = (sb.size() != 0) && (sb[0].cyc + LAT + 2 == cyc);
      chk("resp_valid", 64'(resp_valid), 64'(due));
      if (due) begin
        head = sb.pop_front();
        chk("resp_id", 64'(resp_id), 64'(head.id));
        chk("resp_data", 64'(resp_data), 64'(head.data));
      end
      mon_fire = req_valid & req_ready;
      fired_q  = mon_fire;
      exp_go   = |mon_fire;
      for (int i = 0; i < NR; i++) begin
        if (mon_fire[i]) begin
          exp_a = a_cur[i];
          exp_b = b_cur[i];
          sb.push_back('{id: IDW'(i), data: fsub(a_cur[i], b_cur[i]), cyc: cyc});
        end
      end
      exp_infl = exp_infl + int'(|mon_fire) - int'(due);
    end
  end

  task automatic set_op(input int i);
    a_cur[i] = a_tab[(i + int'(op_cnt[i])) % 8];
    b_cur[i] = b_tab[(3 * i + int'(op_cnt[i])) % 8];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Requesters that fired last cycle move on to their next operands.
  task automatic advance();
    for (int i = 0; i < NR; i++) begin
      if (fired_q[i]) begin
        op_cnt[i]++;
        set_op(i);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int unsigned fire_cyc;

  initial begin
    for (int i = 0; i < NR; i++) begin
      op_cnt[i] = 0;
      set_op(i);
    end
    repeat (3) step();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_fp_go", 64'(fp_go), 64'(0));
    chk("rst_fp_a", 64'(fp_a), 64'(0));
    chk("rst_fp_b", 64'(fp_b), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    reset = 1'b0;
    step(); step();

    // Single request from requester 2: 3.0 - 1.0
    a_cur[2] = 32'h40400000;
    b_cur[2] = 32'h3F800000;
    req_valid = 4'b0100;
    #1;
    chk("single_grant", 64'(req_ready), 64'(4'b0100));
    fire_cyc = cyc;
    step(); req_valid = '0; advance();
    chk("single_go", 64'(fp_go), 64'(1));
    chk("single_fp_a", 64'(fp_a), 64'(32'h40400000));
    chk("single_inflight", 64'(inflight), 64'(1));
    for (int k = 0; k < 40 && resp_valid !== 1'b1; k++) step();
    chk("single_resp_seen", 64'(resp_valid), 64'(1));
    chk("single_resp_id", 64'(resp_id), 64'(2));
    chk("single_resp_data", 64'(resp_data), 64'(32'h40000000));
    chk("single_latency", 64'(cyc - fire_cyc), 64'(16));
    step(); step();
    chk("single_idle", 64'(idle), 64'(1));

    // All four valid continuously from reset
    reset = 1'b1;
    step();
    req_valid = 4'hF;
    step();
    reset = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #1;
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 16) begin
        chk("rr_inflight_sat", 64'(inflight), 64'(16));
        chk("rr_not_idle", 64'(idle), 64'(0));
      end
      step(); advance();
    end
    req_valid = '0;
    repeat (20) step();
    advance();
    chk("rr_drained_idle", 64'(idle), 64'(1));

    // Requesters 1 and 3 with the pointer sitting at 1
    req_valid = 4'b0010;
    #1;
    chk("ptr_setup_grant", 64'(req_ready), 64'(4'b0010));
    step(); advance();
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("alt_grant", 64'(req_ready), 64'((k % 2 == 0) ? 4'b1000 : 4'b0010));
      step(); advance();
    end
    req_valid = '0;
    repeat (20) step();
    advance();

    // Back-to-back fires from requester 0
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b2b_grant", 64'(req_ready), 64'(4'b0001));
      step(); advance();
    end
    req_valid = '0;
    for (int k = 0; k < 40 && resp_valid !== 1'b1; k++) step();
    chk("b2b_resp0", 64'(resp_valid), 64'(1));
    chk("b2b_id0", 64'(resp_id), 64'(0));
    step();
    chk("b2b_resp1", 64'(resp_valid), 64'(1));
    step();
    chk("b2b_resp2", 64'(resp_valid), 64'(1));
    step();
    chk("b2b_resp_end", 64'(resp_valid), 64'(0));
    repeat (16) step();
    advance();

    // Reset while five operations are in flight
    req_valid = 4'hF;
    repeat (5) begin
      step(); advance();
    end
    req_valid = '0;
    repeat (8) step();
    advance();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_fp_go", 64'(fp_go), 64'(0));
    chk("mid_rst_fp_a", 64'(fp_a), 64'(0));
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_resp_data", 64'(resp_data), 64'(0));
    chk("mid_rst_inflight", 64'(inflight), 64'(0));
    chk("mid_rst_idle", 64'(idle), 64'(1));
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("no_stale_resp", 64'(resp_valid), 64'(0));
      step();
    end
    advance();

    // Recovery: a fresh operation still completes normally
    req_valid = 4'b0100;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'(4'b0100));
    step(); req_valid = '0; advance();
    repeat (20) step();
    chk("post_rst_idle", 64'(idle), 64'(1));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
